zoom_redraw_sequencer: RTL
==========================

Name: zoom_redraw_sequencer

Overview:
- Sequences a zoom/pan change for the SRAM frame buffer: it detects a new zoom level or pan offset from the HPS-written PIO registers and waits for vertical blank.
- It then commands the framebuffer clear engine, commits the new view parameters and commands the L-system draw engine to redraw.
- Sits between the zoom/pan PIO outputs and the clear/draw masters. The VGA side only ever shows frames drawn with one consistent view.

Parameters:
PAN_W, 10, width of signed pan offsets (two's complement)
TIMEOUT_W, 24, width of handshake watchdog counter
TIMEOUT_CYCLES, 24'd10_000_000, max cycles to wait for clear_done/draw_done (must be ≥2 and < 2^TIMEOUT_W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
zoom_in  in  2  requested zoom level from zoom PIO out_port
pan_x_in  in  PAN_W  requested signed X pan
pan_y_in  in  PAN_W  requested signed Y pan
frame_start  in  1  one-cycle pulse at start of VGA vertical blank
clear_req  out  1  one-cycle pulse: start framebuffer clear
clear_done  in  1  one-cycle pulse: clear finished
draw_req  out  1  one-cycle pulse: start redraw with active parameters
draw_done  in  1  one-cycle pulse: redraw finished
zoom_active  out  2  committed zoom level
scale_active  out  4  1 << zoom_active (1,2,4,8)
pan_x_active  out  PAN_W  committed X pan
pan_y_active  out  PAN_W  committed Y pan
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky watchdog error flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset values:
  - State IDLE; force=1; all outputs 0, except scale_active=1.
  - Committed registers zoom_active, pan_x_active and pan_y_active = 0.
  - Watchdog counter = 0.
- req (combinational) = force OR ({zoom_in,pan_x_in,pan_y_in} != {zoom_active,pan_x_active,pan_y_active}).
- IDLE:
  - If req, go to WAIT_VB next cycle. Otherwise stay.
  - frame_start is ignored in IDLE.
- WAIT_VB:
  - When frame_start is sampled high at edge N, go to CLEAR.
  - clear_req=1 for exactly cycle N+1. A frame_start in the same cycle that IDLE→WAIT_VB occurs is not counted.
- CLEAR:
  - Watchdog resets to 0 on entry and increments each cycle.
  - clear_done sampled high (including during the clear_req cycle) → COMMIT.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1 → IDLE with timeout_err set. Nothing is committed and force stays as is.
- COMMIT (1 cycle):
  - At the exit edge, load zoom_active/pan_*_active from the current inputs (latest values win). scale_active updates with them. Clear force.
  - Enter DRAW. draw_req=1 for the first DRAW cycle, so the new parameters are stable while draw_req is high.
- DRAW:
  - Watchdog as in CLEAR.
  - draw_done sampled high → IDLE.
  - On timeout → IDLE with timeout_err set. Committed values are kept.
- Changes to the inputs during CLEAR are picked up at COMMIT. Changes during DRAW leave req high, so IDLE immediately starts a new cycle.
- Simultaneous events:
  - done in the same cycle the counter hits TIMEOUT_CYCLES-1: done wins, no error.
  - err_clr together with a new timeout: set wins.
  - clear_done/draw_done pulses outside their wait state are ignored.
  - frame_start outside WAIT_VB is ignored.
- Outputs are registered. busy = (state != IDLE).
- After reset, force guarantees one full clear/draw sequence at the first frame_start.
- Asynchronous reset mid-sequence returns to the reset state immediately and drops any pending req pulses. The upstream engines must treat reset as an abort.

Test Plan:
- Post-reset: inputs 0, frame_start at cycle 20, clear_done 5 cycles after clear_req, draw_done 8 cycles after draw_req.
  - Expect exactly one clear_req and one draw_req, zoom_active=0, scale_active=1, then IDLE with busy=0.
  - A second frame_start produces no pulses.
- Zoom change: zoom_in 0→2 in IDLE.
  - No clear_req until the next frame_start. clear_req one cycle after frame_start.
  - After clear_done: zoom_active=2, scale_active=4, with draw_req in the first cycle those values are valid.
- Late change: pan_x_in=-5 during CLEAR, then pan_x_in=7 during DRAW.
  - Commit gives pan_x_active=-5.
  - After draw_done, a second sequence starts at the next frame_start and commits 7.
- Watchdog: TIMEOUT_CYCLES=16, no clear_done.
  - Exactly 16 cycles after CLEAR entry: timeout_err=1, state IDLE, zoom_active unchanged.
  - Next frame_start retries. err_clr pulse clears the flag.
- Boundary: clear_done on the cycle the counter equals 15 (TIMEOUT_CYCLES=16) → COMMIT, timeout_err stays 0.
  - err_clr and a timeout in the same cycle → timeout_err=1.
- Reset mid-DRAW: assert reset asynchronously (between clock edges).
  - All outputs return to reset values immediately.
  - After release, force causes a full sequence at the next frame_start.

Source files
------------

// File: rtl/zoom_redraw_sequencer.sv
// Sequences a zoom/pan change: waits for vertical blank, clears the frame buffer,
// commits the new view parameters and triggers a redraw, with a handshake watchdog.
module zoom_redraw_sequencer #(
    parameter int                   PAN_W          = 10,
    parameter int                   TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       zoom_in,
    input  logic [PAN_W-1:0] pan_x_in,
    input  logic [PAN_W-1:0] pan_y_in,
    input  logic             frame_start,
    output logic             clear_req,
    input  logic             clear_done,
    output logic             draw_req,
    input  logic             draw_done,
    output logic [1:0]       zoom_active,
    output logic [3:0]       scale_active,
    output logic [PAN_W-1:0] pan_x_active,
    output logic [PAN_W-1:0] pan_y_active,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VB,
        CLEAR,
        COMMIT,
        DRAW
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1'b1;

    state_t               state;
    state_t               state_next;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic [TIMEOUT_W-1:0] wd_cnt_next;
    logic                 force_seq;
    logic                 req;
    logic                 timeout;
    logic                 commit;
    logic                 clear_req_next;
    logic                 draw_req_next;

    // force_seq guarantees one full redraw after reset even if inputs match the reset view
    assign req = force_seq |
                 ({zoom_in, pan_x_in, pan_y_in} != {zoom_active, pan_x_active, pan_y_active});

    always_comb begin
        state_next     = state;
        timeout        = 1'b0;
        commit         = 1'b0;
        clear_req_next = 1'b0;
        draw_req_next  = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_next = WAIT_VB;
            end
            WAIT_VB: begin
                if (frame_start) begin
                    state_next     = CLEAR;
                    clear_req_next = 1'b1;
                end
            end
            CLEAR: begin
                if (clear_done) begin
                    state_next = COMMIT;
                end else if (wd_cnt == TIMEOUT_LAST) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end
            end
            COMMIT: begin
                commit        = 1'b1;
                state_next    = DRAW;
                draw_req_next = 1'b1;
            end
            DRAW: begin
                if (draw_done) begin
                    state_next = IDLE;
                end else if (wd_cnt == TIMEOUT_LAST) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // watchdog restarts from zero on every entry into a handshake wait state
        wd_cnt_next = '0;
        if ((state_next == state) && ((state == CLEAR) || (state == DRAW)))
            wd_cnt_next = wd_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wd_cnt       <= '0;
            force_seq    <= 1'b1;
            clear_req    <= 1'b0;
            draw_req     <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            zoom_active  <= '0;
            scale_active <= 4'd1;
            pan_x_active <= '0;
            pan_y_active <= '0;
        end else begin
            state     <= state_next;
            wd_cnt    <= wd_cnt_next;
            clear_req <= clear_req_next;
            draw_req  <= draw_req_next;
            busy      <= (state_next != IDLE);
            if (commit) begin
                zoom_active  <= zoom_in;
                scale_active <= 4'd1 << zoom_in;
                pan_x_active <= pan_x_in;
                pan_y_active <= pan_y_in;
                force_seq    <= 1'b0;
            end
            // a fresh timeout takes priority over a simultaneous clear request
            if (timeout)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
        end
    end

endmodule
